// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline: datapath widths,
// control-bundle bit layout and ALU operation encodings.
package riscv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 9;

    // Control bundle layout: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, alu_op[3:0]}
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    // A bubble must not write, read or touch memory downstream.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection between the instruction in ID
// and a load sitting in EX.
module load_use_detector (
    input  logic       valid_id_i,
    input  logic       valid_ex_i,
    input  logic       memread_ex_i,
    input  logic [4:0] rd_ex_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic       use_rs1_id_i,
    input  logic       use_rs2_id_i,
    input  logic       flush_ex_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = use_rs1_id_i & (rs1_id_i == rd_ex_i);
    assign rs2_hit = use_rs2_id_i & (rs2_id_i == rd_ex_i);

    // x0 is never a real producer; a flush squashes the consumer anyway.
    assign load_use_o = valid_id_i & valid_ex_i & memread_ex_i & (rd_ex_i != 5'd0)
                      & (rs1_hit | rs2_hit) & ~flush_ex_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands, inserts bubbles on
// load-use hazards and branch flush, holds on memory stall.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = riscv_pipe_pkg::XLEN,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   rs1_data_id,
    input  logic [XLEN-1:0]   rs2_data_id,
    input  logic              mem_stall,
    input  logic              flush_ex,
    output logic              valid_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic              use_rs1_ex,
    output logic              use_rs2_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [XLEN-1:0]   rs1_data_ex,
    output logic [XLEN-1:0]   rs2_data_ex,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  load_use_count
);

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [4:0]        rs1_q,      rs1_d;
    logic [4:0]        rs2_q,      rs2_d;
    logic [4:0]        rd_q,       rd_d;
    logic              use_rs1_q,  use_rs1_d;
    logic              use_rs2_q,  use_rs2_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic              bubble_q,   bubble_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              load_use;

    load_use_detector u_load_use_detector (
        .valid_id_i   (valid_id),
        .valid_ex_i   (valid_q),
        .memread_ex_i (ctrl_q[CTRL_MEMREAD]),
        .rd_ex_i      (rd_q),
        .rs1_id_i     (rs1_id),
        .rs2_id_i     (rs2_id),
        .use_rs1_id_i (use_rs1_id),
        .use_rs2_id_i (use_rs2_id),
        .flush_ex_i   (flush_ex),
        .load_use_o   (load_use)
    );

    assign stall_id = mem_stall | load_use;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        use_rs1_d  = use_rs1_q;
        use_rs2_d  = use_rs2_q;
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        bubble_d   = bubble_q;
        count_d    = count_q;
        // A pending flush during mem_stall is dropped: upstream re-presents it.
        if (mem_stall) begin
            // hold everything
        end else if (flush_ex || load_use) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            use_rs1_d  = 1'b0;
            use_rs2_d  = 1'b0;
            ctrl_d     = BUBBLE_CTRL;
            imm_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            bubble_d   = 1'b1;
            if (!flush_ex && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end else begin
            valid_d    = valid_id;
            pc_d       = pc_id;
            rs1_d      = rs1_id;
            rs2_d      = rs2_id;
            rd_d       = valid_id ? rd_id : 5'd0;
            use_rs1_d  = valid_id & use_rs1_id;
            use_rs2_d  = valid_id & use_rs2_id;
            ctrl_d     = valid_id ? ctrl_id : BUBBLE_CTRL;
            imm_d      = imm_id;
            rs1_data_d = rs1_data_id;
            rs2_data_d = rs2_data_id;
            bubble_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            ctrl_q     <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            bubble_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            use_rs1_q  <= use_rs1_d;
            use_rs2_q  <= use_rs2_d;
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            bubble_q   <= bubble_d;
            count_q    <= count_d;
        end
    end

    assign valid_ex       = valid_q;
    assign pc_ex          = pc_q;
    assign rs1_ex         = rs1_q;
    assign rs2_ex         = rs2_q;
    assign rd_ex          = rd_q;
    assign use_rs1_ex     = use_rs1_q;
    assign use_rs2_ex     = use_rs2_q;
    assign ctrl_ex        = ctrl_q;
    assign imm_ex         = imm_q;
    assign rs1_data_ex    = rs1_data_q;
    assign rs2_data_ex    = rs2_data_q;
    assign bubble_ex      = bubble_q;
    assign load_use_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for the single-cycle
// behaviour plus hand-written stall, saturation and reset sequences.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 9;
    localparam int CNT_W  = 4;

    localparam logic [8:0] C_LOAD  = 9'h1B0;
    localparam logic [8:0] C_ADD   = 9'h100;
    localparam logic [8:0] C_ADDI  = 9'h110;
    localparam logic [8:0] C_STORE = 9'h050;

    logic              clk;
    logic              reset_n;
    logic              valid_id;
    logic [XLEN-1:0]   pc_id;
    logic [4:0]        rs1_id, rs2_id, rd_id;
    logic              use_rs1_id, use_rs2_id;
    logic [CTRL_W-1:0] ctrl_id;
    logic [XLEN-1:0]   imm_id, rs1_data_id, rs2_data_id;
    logic              mem_stall, flush_ex;
    logic              valid_ex;
    logic [XLEN-1:0]   pc_ex;
    logic [4:0]        rs1_ex, rs2_ex, rd_ex;
    logic              use_rs1_ex, use_rs2_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [XLEN-1:0]   imm_ex, rs1_data_ex, rs2_data_ex;
    logic              stall_id, bubble_ex;
    logic [CNT_W-1:0]  load_use_count;

    int tests_run    = 0;
    int tests_failed = 0;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_id       (valid_id),
        .pc_id          (pc_id),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .rd_id          (rd_id),
        .use_rs1_id     (use_rs1_id),
        .use_rs2_id     (use_rs2_id),
        .ctrl_id        (ctrl_id),
        .imm_id         (imm_id),
        .rs1_data_id    (rs1_data_id),
        .rs2_data_id    (rs2_data_id),
        .mem_stall      (mem_stall),
        .flush_ex       (flush_ex),
        .valid_ex       (valid_ex),
        .pc_ex          (pc_ex),
        .rs1_ex         (rs1_ex),
        .rs2_ex         (rs2_ex),
        .rd_ex          (rd_ex),
        .use_rs1_ex     (use_rs1_ex),
        .use_rs2_ex     (use_rs2_ex),
        .ctrl_ex        (ctrl_ex),
        .imm_ex         (imm_ex),
        .rs1_data_ex    (rs1_data_ex),
        .rs2_data_ex    (rs2_data_ex),
        .stall_id       (stall_id),
        .bubble_ex      (bubble_ex),
        .load_use_count (load_use_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rd, rs1, rs2;
        logic       use1, use2;
        logic [8:0] ctrl;
        logic       flush;
        logic       exp_stall;
        logic       exp_valid;
        logic [4:0] exp_rd, exp_rs1;
        logic [8:0] exp_ctrl;
        logic       exp_bubble;
        logic [3:0] exp_cnt;
        logic       exp_pc_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2,
                         input logic [8:0] c, input logic [XLEN-1:0] pc);
        valid_id    = v;
        rd_id       = rd;
        rs1_id      = r1;
        rs2_id      = r2;
        use_rs1_id  = u1;
        use_rs2_id  = u2;
        ctrl_id     = c;
        pc_id       = pc;
        imm_id      = pc + 32'd1;
        rs1_data_id = pc ^ 32'hA5A5_0000;
        rs2_data_id = pc ^ 32'h5A5A_0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid_ex"},  64'(valid_ex), 64'h0);
        check({tag, ".pc_ex"},     64'(pc_ex), 64'h0);
        check({tag, ".rd_ex"},     64'(rd_ex), 64'h0);
        check({tag, ".rs1_ex"},    64'(rs1_ex), 64'h0);
        check({tag, ".rs2_ex"},    64'(rs2_ex), 64'h0);
        check({tag, ".use_ex"},    64'({use_rs1_ex, use_rs2_ex}), 64'h0);
        check({tag, ".ctrl_ex"},   64'(ctrl_ex), 64'h0);
        check({tag, ".imm_ex"},    64'(imm_ex), 64'h0);
        check({tag, ".data_ex"},   64'({rs1_data_ex, rs2_data_ex}), 64'h0);
        check({tag, ".bubble_ex"}, 64'(bubble_ex), 64'h0);
        check({tag, ".count"},     64'(load_use_count), 64'h0);
    endtask

    // One load-use pair: load x5, dependent add stalled once, add re-presented.
    task automatic load_use_pair(input logic [XLEN-1:0] pc);
        drive(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, C_LOAD, pc);
        step();
        drive(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, C_ADD, pc + 32'd4);
        step();
        step();
    endtask

    initial begin
        logic [3:0] cnt_before;

        reset_n    = 1'b0;
        mem_stall  = 1'b0;
        flush_ex   = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'h0, 32'h0);
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        //        name          v  rd  rs1 rs2 u1 u2 ctrl    fl  stall vex rd  rs1 ctrl    bub cnt pc0
        vecs.push_back('{"load_x5",     1, 5,  2,  0,  1, 0, C_LOAD,  0,  0,  1,  5,  2,  C_LOAD,  0, 0, 0});
        vecs.push_back('{"add_dep",     1, 6,  5,  1,  1, 1, C_ADD,   0,  1,  0,  0,  0,  9'h0,    1, 1, 1});
        vecs.push_back('{"add_retry",   1, 6,  5,  1,  1, 1, C_ADD,   0,  0,  1,  6,  5,  C_ADD,   0, 1, 0});
        vecs.push_back('{"load_x0",     1, 0,  3,  0,  1, 0, C_LOAD,  0,  0,  1,  0,  3,  C_LOAD,  0, 1, 0});
        vecs.push_back('{"read_x0",     1, 7,  0,  0,  1, 1, C_ADD,   0,  0,  1,  7,  0,  C_ADD,   0, 1, 0});
        vecs.push_back('{"load_x8",     1, 8,  1,  0,  1, 0, C_LOAD,  0,  0,  1,  8,  1,  C_LOAD,  0, 1, 0});
        vecs.push_back('{"flush_lu",    1, 9,  8,  8,  1, 1, C_ADD,   1,  0,  0,  0,  0,  9'h0,    1, 1, 1});
        vecs.push_back('{"invalid_id",  0, 10, 4,  0,  1, 0, C_ADD,   0,  0,  0,  0,  4,  9'h0,    0, 1, 0});
        vecs.push_back('{"load_x5b",    1, 5,  2,  0,  1, 0, C_LOAD,  0,  0,  1,  5,  2,  C_LOAD,  0, 1, 0});
        vecs.push_back('{"store_rs2",   1, 0,  2,  5,  1, 1, C_STORE, 0,  1,  0,  0,  0,  9'h0,    1, 2, 1});
        vecs.push_back('{"load_x5c",    1, 5,  2,  0,  1, 0, C_LOAD,  0,  0,  1,  5,  2,  C_LOAD,  0, 2, 0});
        vecs.push_back('{"no_use",      1, 11, 5,  5,  0, 0, C_ADDI,  0,  0,  1,  11, 5,  C_ADDI,  0, 2, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            logic [XLEN-1:0] pc;
            pc = 32'h100 + 32'(i * 4);
            drive(vecs[i].valid, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use1,
                  vecs[i].use2, vecs[i].ctrl, pc);
            flush_ex = vecs[i].flush;
            #1;
            check({vecs[i].name, ".stall_id"}, 64'(stall_id), 64'(vecs[i].exp_stall));
            step();
            flush_ex = 1'b0;
            check({vecs[i].name, ".valid_ex"},  64'(valid_ex), 64'(vecs[i].exp_valid));
            check({vecs[i].name, ".rd_ex"},     64'(rd_ex), 64'(vecs[i].exp_rd));
            check({vecs[i].name, ".rs1_ex"},    64'(rs1_ex), 64'(vecs[i].exp_rs1));
            check({vecs[i].name, ".ctrl_ex"},   64'(ctrl_ex), 64'(vecs[i].exp_ctrl));
            check({vecs[i].name, ".bubble_ex"}, 64'(bubble_ex), 64'(vecs[i].exp_bubble));
            check({vecs[i].name, ".count"},     64'(load_use_count), 64'(vecs[i].exp_cnt));
            check({vecs[i].name, ".pc_ex"},     64'(pc_ex), vecs[i].exp_pc_zero ? 64'h0 : 64'(pc));
        end

        // mem_stall for 3 cycles with a load-use pending
        drive(1'b1, 5'd12, 5'd1, 5'd0, 1'b1, 1'b0, C_LOAD, 32'h200);
        step();
        drive(1'b1, 5'd13, 5'd12, 5'd0, 1'b1, 1'b0, C_ADD, 32'h204);
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mstall.stall_id", 64'(stall_id), 64'h1);
            step();
            check("mstall.rd_ex",     64'(rd_ex), 64'd12);
            check("mstall.ctrl_ex",   64'(ctrl_ex), 64'(C_LOAD));
            check("mstall.pc_ex",     64'(pc_ex), 64'h200);
            check("mstall.bubble_ex", 64'(bubble_ex), 64'h0);
            check("mstall.count",     64'(load_use_count), 64'd2);
        end
        mem_stall = 1'b0;
        #1;
        check("release.stall_id", 64'(stall_id), 64'h1);
        step();
        check("release.bubble_ex", 64'(bubble_ex), 64'h1);
        check("release.valid_ex",  64'(valid_ex), 64'h0);
        check("release.count",     64'(load_use_count), 64'd3);
        #1;
        check("after.stall_id", 64'(stall_id), 64'h0);
        step();
        check("after.rd_ex",     64'(rd_ex), 64'd13);
        check("after.rs1_ex",    64'(rs1_ex), 64'd12);
        check("after.bubble_ex", 64'(bubble_ex), 64'h0);
        check("after.count",     64'(load_use_count), 64'd3);

        // Saturation: 17 further load-use events on a 4-bit counter
        for (int k = 0; k < 17; k++) begin
            cnt_before = load_use_count;
            load_use_pair(32'h300 + 32'(k * 8));
            if (k == 0) check("sat.first_inc", 64'(load_use_count), 64'(cnt_before) + 64'd1);
        end
        check("sat.count",  64'(load_use_count), 64'hF);
        check("sat.rd_ex",  64'(rd_ex), 64'd6);

        // Asynchronous reset mid-operation, away from any clock edge
        drive(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, C_LOAD, 32'h400);
        step();
        check("prereset.valid_ex", 64'(valid_ex), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("async_reset.stall_id", 64'(stall_id), 64'h0);
        step();
        reset_n = 1'b1;
        drive(1'b1, 5'd14, 5'd3, 5'd4, 1'b1, 1'b1, C_ADD, 32'h500);
        step();
        check("post_reset.valid_ex", 64'(valid_ex), 64'h1);
        check("post_reset.rd_ex",    64'(rd_ex), 64'd14);
        check("post_reset.imm_ex",   64'(imm_ex), 64'h501);
        check("post_reset.rs2_data", 64'(rs2_data_ex), 64'(32'h500 ^ 32'h5A5A_0000));
        check("post_reset.count",    64'(load_use_count), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
